controlador_processamento: RTL and testbench

Sequencing controller for the image coprocessor's pixel pipeline. On a start command it walks every pixel address of the source image, reads each pixel from the source image RAM, presents it to the selected processing algorithm, and writes the result to the destination RAM at the same index. It sits between the HPS-facing command registers and the image memories and algorithm datapath, and reports busy, done and error status back to the command interface.

---
 rtl/controlador_processamento_pkg.sv | 25 ++
 rtl/controlador_processamento_detector_borda.sv | 29 ++
 rtl/controlador_processamento.sv | 159 +++++++++++++++
 tb/tb_controlador_processamento.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_processamento_pkg.sv
// Shared definitions for the pixel pipeline sequencing controller.
//   - algorithm opcode constants (valid range OP_COPIA..OP_MAX)
//   - FSM state encoding
//   - pixel width
package controlador_processamento_pkg;

    localparam int PIXEL_W = 8;

    localparam logic [2:0] OP_COPIA = 3'd0;
    localparam logic [2:0] OP_1     = 3'd1;
    localparam logic [2:0] OP_2     = 3'd2;
    localparam logic [2:0] OP_3     = 3'd3;
    localparam logic [2:0] OP_4     = 3'd4;
    localparam logic [2:0] OP_MAX   = OP_4;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LER      = 3'd1,
        ESPERA   = 3'd2,
        PROCESSA = 3'd3,
        ESCREVE  = 3'd4,
        FIM      = 3'd5
    } estado_t;

endpackage

// File: rtl/controlador_processamento_detector_borda.sv
// Registered rising-edge detector for the start command.
//   clk     : clock, registers update on the falling edge
//   reset   : synchronous active-low reset
//   i_sinal : level input (start command)
//   o_borda : high while i_sinal=1 and the previously registered value was 0
// The D stage clears on reset, so a level held high through reset release
// is reported as a fresh edge.
module detector_borda
    import controlador_processamento_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_sinal,
    output logic o_borda
);

    logic r_anterior;

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_anterior <= 1'b0;
        end else begin
            r_anterior <= i_sinal;
        end
    end

    assign o_borda = i_sinal & ~r_anterior;

endmodule

// File: rtl/controlador_processamento.sv
// Sequencing controller for the image coprocessor pixel pipeline.
// On a start edge it walks every pixel index 0..N-1: read source RAM,
// wait LAT_MEM cycles, hand the pixel to the algorithm, write the result to
// the destination RAM at the same index.
//   clk, reset          : falling-edge clock, synchronous active-low reset
//   inicio, opcode      : start level and algorithm select
//   opcode_ativo        : opcode latched at the accepted start
//   ocupado/concluido   : busy level / end-of-image pulse
//   erro                : sticky invalid-opcode flag
//   ler, end_leitura, dado_lido        : source RAM read port
//   px_entrada, px_resultado           : algorithm datapath
//   escrever, end_escrita, dado_escrita: destination RAM write port
module controlador_processamento
    import controlador_processamento_pkg::*;
#(
    parameter int LARGURA = 160,
    parameter int ALTURA  = 120,
    parameter int ADDR_W  = 15,
    parameter int LAT_MEM = 2
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                inicio,
    input  logic [2:0]          opcode,
    output logic [2:0]          opcode_ativo,
    output logic                ocupado,
    output logic                concluido,
    output logic                erro,
    output logic                ler,
    output logic [ADDR_W-1:0]   end_leitura,
    input  logic [PIXEL_W-1:0]  dado_lido,
    output logic [PIXEL_W-1:0]  px_entrada,
    input  logic [PIXEL_W-1:0]  px_resultado,
    output logic                escrever,
    output logic [ADDR_W-1:0]   end_escrita,
    output logic [PIXEL_W-1:0]  dado_escrita
);

    localparam int N = LARGURA * ALTURA;
    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N - 1);
    localparam int CNT_W = (LAT_MEM > 1) ? $clog2(LAT_MEM) : 1;
    localparam logic [CNT_W-1:0] ESPERA_FIM = CNT_W'(LAT_MEM - 1);

    estado_t              r_estado, w_estado_next;
    logic [ADDR_W-1:0]    r_indice, w_indice_next;
    logic [2:0]           r_opcode, w_opcode_next;
    logic                 r_erro, w_erro_next;
    logic [CNT_W-1:0]     r_espera, w_espera_next;
    logic [PIXEL_W-1:0]   r_px, w_px_next;
    logic [PIXEL_W-1:0]   r_dado, w_dado_next;
    logic [ADDR_W-1:0]    r_end_esc, w_end_esc_next;
    logic                 w_borda;

    detector_borda u_detector_borda (
        .clk     (clk),
        .reset   (reset),
        .i_sinal (inicio),
        .o_borda (w_borda)
    );

    always_ff @(negedge clk) begin
        if (!reset) begin
            r_estado  <= OCIOSO;
            r_indice  <= '0;
            r_opcode  <= '0;
            r_erro    <= 1'b0;
            r_espera  <= '0;
            r_px      <= '0;
            r_dado    <= '0;
            r_end_esc <= '0;
        end else begin
            r_estado  <= w_estado_next;
            r_indice  <= w_indice_next;
            r_opcode  <= w_opcode_next;
            r_erro    <= w_erro_next;
            r_espera  <= w_espera_next;
            r_px      <= w_px_next;
            r_dado    <= w_dado_next;
            r_end_esc <= w_end_esc_next;
        end
    end

    always_comb begin
        w_estado_next  = r_estado;
        w_indice_next  = r_indice;
        w_opcode_next  = r_opcode;
        w_erro_next    = r_erro;
        w_espera_next  = r_espera;
        w_px_next      = r_px;
        w_dado_next    = r_dado;
        w_end_esc_next = r_end_esc;
        ocupado        = 1'b1;
        concluido      = 1'b0;
        ler            = 1'b0;
        escrever       = 1'b0;

        case (r_estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (w_borda) begin
                    if (opcode <= OP_MAX) begin
                        w_opcode_next = opcode;
                        w_erro_next   = 1'b0;
                        w_indice_next = '0;
                        w_estado_next = LER;
                    end else begin
                        // invalid opcode: flag it and stay idle, no memory traffic
                        w_erro_next = 1'b1;
                    end
                end
            end
            LER: begin
                ler           = 1'b1;
                w_espera_next = '0;
                w_estado_next = ESPERA;
            end
            ESPERA: begin
                // read data is valid only on the last wait cycle
                if (r_espera == ESPERA_FIM) begin
                    w_px_next     = dado_lido;
                    w_estado_next = PROCESSA;
                end else begin
                    w_espera_next = r_espera + 1'b1;
                end
            end
            PROCESSA: begin
                w_dado_next    = px_resultado;
                w_end_esc_next = r_indice;
                w_estado_next  = ESCREVE;
            end
            ESCREVE: begin
                escrever = 1'b1;
                if (r_indice == ULTIMO) begin
                    w_estado_next = FIM;
                end else begin
                    w_indice_next = r_indice + 1'b1;
                    w_estado_next = LER;
                end
            end
            FIM: begin
                concluido     = 1'b1;
                w_estado_next = OCIOSO;
            end
            default: begin
                ocupado       = 1'b0;
                w_estado_next = OCIOSO;
            end
        endcase
    end

    // the read address is the live index, so it keeps its last value while idle
    assign end_leitura  = r_indice;
    assign opcode_ativo = r_opcode;
    assign erro         = r_erro;
    assign px_entrada   = r_px;
    assign dado_escrita = r_dado;
    assign end_escrita  = r_end_esc;

endmodule

// File: tb/tb_controlador_processamento.sv
module tb_controlador_processamento;

    localparam int LARG = 4;
    localparam int ALT  = 2;
    localparam int AW   = 4;
    localparam int LAT  = 2;
    localparam int N    = LARG * ALT;
    localparam int PER  = LAT + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          inicio = 1'b0;
    logic [2:0]    opcode = 3'd0;
    logic [2:0]    opcode_ativo;
    logic          ocupado, concluido, erro, ler, escrever;
    logic [AW-1:0] end_leitura, end_escrita;
    logic [7:0]    dado_lido, px_entrada, px_resultado, dado_escrita;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    controlador_processamento #(
        .LARGURA(LARG), .ALTURA(ALT), .ADDR_W(AW), .LAT_MEM(LAT)
    ) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .opcode(opcode),
        .opcode_ativo(opcode_ativo), .ocupado(ocupado), .concluido(concluido),
        .erro(erro), .ler(ler), .end_leitura(end_leitura), .dado_lido(dado_lido),
        .px_entrada(px_entrada), .px_resultado(px_resultado), .escrever(escrever),
        .end_escrita(end_escrita), .dado_escrita(dado_escrita)
    );

    // algorithm stand-in: any opcode-dependent function exposes a wrong latch
    function automatic logic [7:0] alg(input logic [7:0] x, input logic [2:0] op);
        return (x ^ 8'h5A) + {5'b0, op};
    endfunction
    assign px_resultado = alg(px_entrada, opcode_ativo);

    // source RAM: data appears exactly LAT cycles after the read strobe
    logic [7:0]    mem [16];
    logic [AW-1:0] pipe_a [LAT];
    logic          pipe_v [LAT];
    always @(negedge clk) begin
        pipe_v[0] <= ler;
        pipe_a[0] <= end_leitura;
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign dado_lido = pipe_v[LAT-1] ? mem[pipe_a[LAT-1]] : 8'hEE;

    // event log, sampled on the rising edge (away from the DUT's falling edge)
    typedef struct { int c; int a; int d; } ev_t;
    ev_t ler_q[$];
    ev_t esc_q[$];
    int  conc_q[$];
    int  cyc = 0;
    int  overlap = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ler) ler_q.push_back('{cyc, int'(end_leitura), 0});
        if (escrever) begin
            esc_q.push_back('{cyc, int'(end_escrita), int'(dado_escrita)});
            $display("write addr=%0d data=0x%02h cycle=%0d", end_escrita, dado_escrita, cyc);
        end
        if (concluido) conc_q.push_back(cyc);
        if (ler && escrever) overlap <= overlap + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ocupado"}, ocupado, 0);
        chk({tag, "_concluido"}, concluido, 0);
        chk({tag, "_erro"}, erro, 0);
        chk({tag, "_ler"}, ler, 0);
        chk({tag, "_escrever"}, escrever, 0);
        chk({tag, "_opcode_ativo"}, opcode_ativo, 0);
        chk({tag, "_end_leitura"}, end_leitura, 0);
        chk({tag, "_end_escrita"}, end_escrita, 0);
        chk({tag, "_px_entrada"}, px_entrada, 0);
        chk({tag, "_dado_escrita"}, dado_escrita, 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < N * PER + 20; i++) begin
            @(posedge clk);
            if (concluido) break;
        end
        repeat (3) @(posedge clk);
    endtask

    // compare the logged traffic since the given bases with the expected image pass
    task automatic check_run(input int bl, input int be, input int bc, input int bo,
                             input logic [2:0] op, input bit valid);
        int nl, ne, nc;
        nl = ler_q.size() - bl;
        ne = esc_q.size() - be;
        nc = conc_q.size() - bc;
        chk("n_ler", nl, valid ? N : 0);
        chk("n_escrever", ne, valid ? N : 0);
        chk("n_concluido", nc, valid ? 1 : 0);
        chk("ler_escrever_overlap", overlap - bo, 0);
        if (valid && nl == N && ne == N && nc == 1) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("ler_addr[%0d]", i), ler_q[bl+i].a, i);
                chk($sformatf("esc_addr[%0d]", i), esc_q[be+i].a, i);
                chk($sformatf("esc_data[%0d]", i), esc_q[be+i].d, int'(alg(mem[i], op)));
                chk($sformatf("ler_to_esc[%0d]", i), esc_q[be+i].c - ler_q[bl+i].c, LAT + 2);
                if (i > 0)
                    chk($sformatf("ler_spacing[%0d]", i), ler_q[bl+i].c - ler_q[bl+i-1].c, PER);
            end
            chk("image_cycles", conc_q[bc] - ler_q[bl].c + 1, N * PER + 1);
            chk("opcode_ativo", opcode_ativo, op);
        end
        $display("run op=%0d valid=%0d ler=%0d writes=%0d done=%0d", op, valid, nl, ne, nc);
    endtask

    task automatic run_op(input logic [2:0] op, input bit exp_erro, input bit exp_ler);
        int bl, be, bc, bo;
        bl = ler_q.size(); be = esc_q.size(); bc = conc_q.size(); bo = overlap;
        @(posedge clk);
        inicio = 1'b1;
        opcode = op;
        @(posedge clk);
        chk("start_ler", ler, exp_ler);
        chk("start_ocupado", ocupado, exp_ler);
        chk("start_erro", erro, exp_erro);
        inicio = 1'b0;
        if (exp_ler) wait_done();
        else repeat (8) @(posedge clk);
        chk("idle_ocupado", ocupado, 0);
        chk("erro_hold", erro, exp_erro);
        check_run(bl, be, bc, bo, op, exp_ler);
    endtask

    typedef struct { logic [2:0] op; bit exp_erro; bit exp_ler; } vec_t;
    vec_t tbl [8];

    initial begin
        int bl, be, bc, bo;
        logic [2:0] op;
        bit found;

        tbl[0] = '{3'd1, 1'b0, 1'b1};
        tbl[1] = '{3'd6, 1'b1, 1'b0};
        tbl[2] = '{3'd3, 1'b0, 1'b1};
        tbl[3] = '{3'd7, 1'b1, 1'b0};
        tbl[4] = '{3'd5, 1'b1, 1'b0};
        tbl[5] = '{3'd4, 1'b0, 1'b1};
        tbl[6] = '{3'd0, 1'b0, 1'b1};
        tbl[7] = '{3'd2, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 10);

        // reset state
        reset = 1'b0;
        repeat (3) @(posedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        chk("idle_after_reset_ler", ler, 0);

        // opcode table: valid runs, invalid flags, erro cleared by next valid start
        for (int i = 0; i < 8; i++) run_op(tbl[i].op, tbl[i].exp_erro, tbl[i].exp_ler);

        // extra edges during the run, then inicio held high past FIM
        bl = ler_q.size(); be = esc_q.size(); bc = conc_q.size(); bo = overlap;
        @(posedge clk);
        inicio = 1'b1;
        opcode = 3'd2;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            inicio = (k % 7 == 3) ? 1'b0 : 1'b1;
        end
        inicio = 1'b1;
        wait_done();
        repeat (30) @(posedge clk);
        check_run(bl, be, bc, bo, 3'd2, 1'b1);
        inicio = 1'b0;
        repeat (2) @(posedge clk);

        // reset during the wait of pixel 3, then restart with inicio held high
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        be = esc_q.size();
        @(posedge clk);
        inicio = 1'b1;
        opcode = 3'd3;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            if (ler && end_leitura == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("found_pixel3_ler", found, 1);
        @(posedge clk);
        chk("pixel3_in_wait_ler", ler, 0);
        reset = 1'b0;
        @(posedge clk);
        chk_reset_outputs("midrun_reset");
        @(posedge clk);
        chk("aborted_writes", esc_q.size() - be, 3);
        bl = ler_q.size(); be = esc_q.size(); bc = conc_q.size(); bo = overlap;
        reset = 1'b1;
        @(posedge clk);
        chk("restart_ler", ler, 1);
        chk("restart_addr", end_leitura, 0);
        wait_done();
        repeat (10) @(posedge clk);
        check_run(bl, be, bc, bo, 3'd3, 1'b1);
        inicio = 1'b0;
        repeat (2) @(posedge clk);

        // randomized runs against the model: opcode valid iff 0..4
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            op = 3'($urandom_range(0, 7));
            run_op(op, op > 3'd4, op <= 3'd4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
